// File: rtl/switchesqsys_nios2_processor_oci_dct_ctrl_pkg.sv
// Shared definitions for the OCI DCT trace-buffer controller:
// entry/buffer geometry, branch-outcome codes and controller states.
package switchesqsys_oci_dct_pkg;

  localparam int ENTRY_W = 2;
  localparam int DEPTH   = 15;
  localparam int BUF_W   = ENTRY_W * DEPTH;
  localparam int CNT_W   = 4;

  // Branch-outcome codes carried in each entry
  localparam logic [ENTRY_W-1:0] DCT_NOT_TAKEN = 2'b00;
  localparam logic [ENTRY_W-1:0] DCT_TAKEN     = 2'b01;
  localparam logic [ENTRY_W-1:0] DCT_INDIRECT  = 2'b10;
  localparam logic [ENTRY_W-1:0] DCT_EXCEPTION = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } dct_state_e;

  // Write one entry code into slot idx of a fill buffer; other slots untouched.
  function automatic logic [BUF_W-1:0] put_entry(input logic [BUF_W-1:0]   buf_in,
                                                 input logic [CNT_W-1:0]   idx,
                                                 input logic [ENTRY_W-1:0] code);
    logic [BUF_W-1:0] r;
    r = buf_in;
    for (int i = 0; i < DEPTH; i++) begin
      if (idx == CNT_W'(i)) r[i*ENTRY_W +: ENTRY_W] = code;
    end
    return r;
  endfunction

endpackage

// File: rtl/switchesqsys_nios2_processor_oci_dct_ctrl_if.sv
// Bundle of the trace-entry input, packet handshake and live-view signals.
// Optional SWITCHESQSYS_OCI_DCT_DROP_CNT_EN adds the drop_count signal.
interface switchesqsys_nios2_processor_oci_dct_ctrl_if;
  import switchesqsys_oci_dct_pkg::*;

  logic               trc_on;
  logic               dct_valid;
  logic [ENTRY_W-1:0] dct_code;
  logic               flush_req;
  logic               pkt_valid;
  logic               pkt_ready;
  logic [BUF_W-1:0]   pkt_buffer;
  logic [CNT_W-1:0]   pkt_count;
  logic [BUF_W-1:0]   dct_buffer;
  logic [CNT_W-1:0]   dct_count;
  logic               overflow;
  logic               busy;
`ifdef SWITCHESQSYS_OCI_DCT_DROP_CNT_EN
  logic [7:0]         drop_count;
`endif

  // Controller side
  modport master (
    input  trc_on, dct_valid, dct_code, flush_req, pkt_ready,
    output pkt_valid, pkt_buffer, pkt_count, dct_buffer, dct_count, overflow, busy
`ifdef SWITCHESQSYS_OCI_DCT_DROP_CNT_EN
    , output drop_count
`endif
  );

  // Trace source / packet sink side
  modport slave (
    output trc_on, dct_valid, dct_code, flush_req, pkt_ready,
    input  pkt_valid, pkt_buffer, pkt_count, dct_buffer, dct_count, overflow, busy
`ifdef SWITCHESQSYS_OCI_DCT_DROP_CNT_EN
    , input drop_count
`endif
  );

endinterface

// File: rtl/switchesqsys_nios2_processor_oci_dct_ctrl_pkt_reg.sv
// Packet holding register with valid/ready output handshake.
// A load while the previous packet is being accepted replaces it in place,
// so back-to-back packets keep valid high.
module switchesqsys_oci_dct_pkt_reg
  import switchesqsys_oci_dct_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BUF_W-1:0] payload,
  input  logic [CNT_W-1:0] count,
  input  logic             ready,
  output logic             valid,
  output logic [BUF_W-1:0] buffer,
  output logic [CNT_W-1:0] held_count,
  output logic             stall
);

  logic             valid_q;
  logic [BUF_W-1:0] buffer_q;
  logic [CNT_W-1:0] count_q;

  // Held packet cannot be replaced while offered and not accepted
  assign stall = valid_q & ~ready;

  // Capture a new packet on load; retire the held one on transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      buffer_q <= '0;
      count_q  <= '0;
    end else if (load) begin
      valid_q  <= 1'b1;
      buffer_q <= payload;
      count_q  <= count;
    end else if (valid_q && ready) begin
      valid_q  <= 1'b0;
    end
  end

  assign valid      = valid_q;
  assign buffer     = buffer_q;
  assign held_count = count_q;

endmodule

// File: rtl/switchesqsys_nios2_processor_oci_dct_ctrl.sv
// OCI DCT trace-buffer controller: packs 2-bit branch codes into a 15-entry
// fill buffer and hands full or flushed buffers to the packet sink.
// Optional feature macro: SWITCHESQSYS_OCI_DCT_DROP_CNT_EN (saturating drop_count).
module switchesqsys_nios2_processor_oci_dct_ctrl
  import switchesqsys_oci_dct_pkg::*;
(
  input logic clk,
  input logic reset,
  switchesqsys_nios2_processor_oci_dct_ctrl_if.master bus
);

  logic [BUF_W-1:0] fill_q;
  logic [CNT_W-1:0] cnt_q;
  logic             trc_q;
  logic             flush_pend_q;
  logic             ovf_q;
  dct_state_e       state_q;

  logic [BUF_W-1:0] fill_acc;
  logic [CNT_W-1:0] cnt_acc;
  logic [CNT_W-1:0] cnt_nxt;
  dct_state_e       state_nxt;
  logic             accept;
  logic             full;
  logic             wr;
  logic             drop;
  logic             trc_fall;
  logic             trc_rise;
  logic             flush_want;
  logic             emit;
  logic             load;
  logic             stall;
  logic             pkt_valid;
  logic             pkt_valid_nxt;
  logic [BUF_W-1:0] pkt_buffer;
  logic [CNT_W-1:0] pkt_count;

  assign accept   = bus.trc_on & bus.dct_valid;
  assign full     = (cnt_q == CNT_W'(DEPTH));
  // A full fill buffer can only exist while the emit is stalled; extra entries are lost
  assign wr       = accept & ~full;
  assign drop     = accept & full;
  assign trc_fall = trc_q & ~bus.trc_on;
  assign trc_rise = ~trc_q & bus.trc_on;

  // Fill buffer and count as they stand after this cycle's accept
  always_comb begin
    fill_acc = fill_q;
    cnt_acc  = cnt_q;
    if (wr) begin
      fill_acc = put_entry(fill_q, cnt_q, bus.dct_code);
      cnt_acc  = cnt_q + CNT_W'(1);
    end
  end

  // Flush requests (explicit, trace-off edge, or stalled earlier) need a non-empty buffer
  assign flush_want = (bus.flush_req | trc_fall | flush_pend_q) & (cnt_acc != '0);
  assign emit       = (cnt_acc == CNT_W'(DEPTH)) | flush_want;
  assign load       = emit & ~stall;

  // Next-state view used for the registered state/busy output
  always_comb begin
    cnt_nxt       = load ? '0 : cnt_acc;
    pkt_valid_nxt = load | stall;
    if (pkt_valid_nxt)       state_nxt = HOLD;
    else if (cnt_nxt != '0)  state_nxt = FILL;
    else                     state_nxt = IDLE;
  end

  // Fill buffer, pending flush, overflow and state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q       <= '0;
      cnt_q        <= '0;
      trc_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      ovf_q        <= 1'b0;
      state_q      <= IDLE;
    end else begin
      trc_q        <= bus.trc_on;
      fill_q       <= load ? '0 : fill_acc;
      cnt_q        <= cnt_nxt;
      flush_pend_q <= flush_want & ~load;
      state_q      <= state_nxt;
      if (drop)          ovf_q <= 1'b1;
      else if (trc_rise) ovf_q <= 1'b0;
    end
  end

`ifdef SWITCHESQSYS_OCI_DCT_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Saturating count of dropped entries, cleared together with overflow
  always_ff @(posedge clk) begin
    if (reset)         drop_cnt_q <= '0;
    else if (drop)     drop_cnt_q <= sat_inc(drop_cnt_q);
    else if (trc_rise) drop_cnt_q <= '0;
  end

  assign bus.drop_count = drop_cnt_q;
`endif

  switchesqsys_oci_dct_pkt_reg u_pkt_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .payload    (fill_acc),
    .count      (cnt_acc),
    .ready      (bus.pkt_ready),
    .valid      (pkt_valid),
    .buffer     (pkt_buffer),
    .held_count (pkt_count),
    .stall      (stall)
  );

  assign bus.pkt_valid  = pkt_valid;
  assign bus.pkt_buffer = pkt_buffer;
  assign bus.pkt_count  = pkt_count;
  assign bus.dct_buffer = fill_q;
  assign bus.dct_count  = cnt_q;
  assign bus.overflow   = ovf_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_switchesqsys_nios2_processor_oci_dct_ctrl.sv
// Scoreboard bench for the OCI DCT controller: expected packets are queued by
// the stimulus, a negedge monitor pops and compares on every transfer.
module tb_switchesqsys_nios2_processor_oci_dct_ctrl;

  typedef struct packed {
    logic [29:0] b;
    logic [3:0]  c;
  } pkt_t;

  logic clk;
  logic reset;
  pkt_t exp_q[$];
  int   n_chk;
  int   n_pass;

  logic        prev_hold;
  logic [29:0] prev_buf;
  logic [3:0]  prev_cnt;

  switchesqsys_nios2_processor_oci_dct_ctrl_if bus ();

  switchesqsys_nios2_processor_oci_dct_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [29:0] b, input logic [3:0] c);
    pkt_t p;
    p.b = b;
    p.c = c;
    exp_q.push_back(p);
  endtask

  // Monitor: stability while stalled, scoreboard compare on each transfer
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(bus.pkt_valid), 32'd1);
        check("hold_buffer", 32'(bus.pkt_buffer), 32'(prev_buf));
        check("hold_count", 32'(bus.pkt_count), 32'(prev_cnt));
      end
      if (bus.pkt_valid && bus.pkt_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_pkt: got buffer %0h count %0d expected none",
                   bus.pkt_buffer, bus.pkt_count);
        end else begin
          pkt_t e;
          e = exp_q.pop_front();
          check("pkt_buffer", 32'(bus.pkt_buffer), 32'(e.b));
          check("pkt_count", 32'(bus.pkt_count), 32'(e.c));
        end
      end
      prev_hold = bus.pkt_valid & ~bus.pkt_ready;
      prev_buf  = bus.pkt_buffer;
      prev_cnt  = bus.pkt_count;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] codes [3];
    codes[0] = 2'b00; codes[1] = 2'b01; codes[2] = 2'b10;
    n_chk = 0;
    n_pass = 0;
    prev_hold = 1'b0;
    reset = 1'b1;
    bus.trc_on = 1'b0;
    bus.dct_valid = 1'b0;
    bus.dct_code = 2'b00;
    bus.flush_req = 1'b0;
    bus.pkt_ready = 1'b0;
    tick();
    tick();
    check("rst_pkt_valid", 32'(bus.pkt_valid), 32'd0);
    check("rst_dct_count", 32'(bus.dct_count), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_pkt_count", 32'(bus.pkt_count), 32'd0);

    // Full buffer of taken codes with sink ready
    reset = 1'b0;
    bus.trc_on = 1'b1;
    bus.pkt_ready = 1'b1;
    push(30'h15555555, 4'd15);
    for (int i = 0; i < 15; i++) begin
      bus.dct_valid = 1'b1;
      bus.dct_code = 2'b01;
      tick();
      if (i == 13) check("fill14_count", 32'(bus.dct_count), 32'd14);
    end
    bus.dct_valid = 1'b0;
    check("full_pkt_valid", 32'(bus.pkt_valid), 32'd1);
    check("full_dct_count", 32'(bus.dct_count), 32'd0);
    check("full_busy", 32'(bus.busy), 32'd1);
    tick();
    check("full_drained", 32'(bus.pkt_valid), 32'd0);
    check("full_idle", 32'(bus.busy), 32'd0);

    // Three entries then flush, sink initially not ready
    bus.pkt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.dct_valid = 1'b1;
      bus.dct_code = codes[i];
      tick();
    end
    bus.dct_valid = 1'b0;
    check("three_count", 32'(bus.dct_count), 32'd3);
    check("three_buffer", 32'(bus.dct_buffer), 32'h24);
    check("three_busy", 32'(bus.busy), 32'd1);
    push(30'h24, 4'd3);
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    check("flush_valid", 32'(bus.pkt_valid), 32'd1);
    check("flush_pkt_count", 32'(bus.pkt_count), 32'd3);
    check("flush_dct_count", 32'(bus.dct_count), 32'd0);
    repeat (3) tick();
    check("flush_held", 32'(bus.pkt_valid), 32'd1);
    bus.pkt_ready = 1'b1;
    tick();
    check("flush_drained", 32'(bus.pkt_valid), 32'd0);

    // Flush with empty buffer is ignored; accept plus flush gives one-entry packet
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    check("empty_flush_valid", 32'(bus.pkt_valid), 32'd0);
    check("empty_flush_busy", 32'(bus.busy), 32'd0);
    push(30'h2, 4'd1);
    bus.dct_valid = 1'b1;
    bus.dct_code = 2'b10;
    bus.flush_req = 1'b1;
    tick();
    bus.dct_valid = 1'b0;
    bus.flush_req = 1'b0;
    check("acc_flush_valid", 32'(bus.pkt_valid), 32'd1);
    check("acc_flush_count", 32'(bus.pkt_count), 32'd1);
    tick();

    // Stalled sink: 32 exception entries -> one held, one full, two dropped
    bus.pkt_ready = 1'b0;
    push(30'h3FFFFFFF, 4'd15);
    push(30'h3FFFFFFF, 4'd15);
    for (int i = 0; i < 32; i++) begin
      bus.dct_valid = 1'b1;
      bus.dct_code = 2'b11;
      tick();
    end
    bus.dct_valid = 1'b0;
    check("ovf_dct_count", 32'(bus.dct_count), 32'd15);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    check("ovf_pkt_valid", 32'(bus.pkt_valid), 32'd1);
`ifdef SWITCHESQSYS_OCI_DCT_DROP_CNT_EN
    check("drop_count", 32'(bus.drop_count), 32'd2);
`endif
    bus.pkt_ready = 1'b1;
    tick();
    check("b2b_valid", 32'(bus.pkt_valid), 32'd1);
    check("b2b_dct_count", 32'(bus.dct_count), 32'd0);
    tick();
    check("b2b_drained", 32'(bus.pkt_valid), 32'd0);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Trace-off edge auto-flushes five entries
    for (int i = 0; i < 5; i++) begin
      bus.dct_valid = 1'b1;
      bus.dct_code = 2'b01;
      tick();
    end
    bus.dct_valid = 1'b0;
    check("five_count", 32'(bus.dct_count), 32'd5);
    check("five_buffer", 32'(bus.dct_buffer), 32'h155);
    push(30'h155, 4'd5);
    bus.trc_on = 1'b0;
    tick();
    check("trcoff_valid", 32'(bus.pkt_valid), 32'd1);
    check("trcoff_pkt_count", 32'(bus.pkt_count), 32'd5);
    check("trcoff_dct_count", 32'(bus.dct_count), 32'd0);
    bus.dct_valid = 1'b1;
    bus.dct_code = 2'b11;
    tick();
    bus.dct_valid = 1'b0;
    check("trcoff_ignored", 32'(bus.dct_count), 32'd0);
    check("trcoff_drained", 32'(bus.pkt_valid), 32'd0);
    bus.trc_on = 1'b1;
    tick();
    check("trcon_ovf_clear", 32'(bus.overflow), 32'd0);
`ifdef SWITCHESQSYS_OCI_DCT_DROP_CNT_EN
    check("drop_count_clear", 32'(bus.drop_count), 32'd0);
`endif

    // Reset while a packet is held discards it
    bus.pkt_ready = 1'b0;
    bus.dct_valid = 1'b1;
    bus.dct_code = 2'b01;
    bus.flush_req = 1'b1;
    tick();
    bus.dct_valid = 1'b0;
    bus.flush_req = 1'b0;
    check("pre_rst_valid", 32'(bus.pkt_valid), 32'd1);
    reset = 1'b1;
    tick();
    check("midrst_valid", 32'(bus.pkt_valid), 32'd0);
    check("midrst_buffer", 32'(bus.pkt_buffer), 32'd0);
    check("midrst_pkt_count", 32'(bus.pkt_count), 32'd0);
    check("midrst_dct_count", 32'(bus.dct_count), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    bus.pkt_ready = 1'b1;
    tick();
    tick();
    check("post_rst_valid", 32'(bus.pkt_valid), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
